// File: rtl/cpu_clk_ctrl.sv
// cpu_clk_ctrl: run/halt/step clock-enable scheduler with selectable tick rate,
// debounced single-step button and processor halt trap.
module cpu_clk_ctrl #(
    parameter int DEBOUNCE_CYC = 500000,
    parameter int CNT_W = 26
) (
    input  logic       clkIn,
    input  logic       rstN,
    input  logic [2:0] rate_sel,
    input  logic       run_en,
    input  logic       step_btn,
    input  logic       halt_req,
    output logic       tick,
    output logic       clkOut,
    output logic       running,
    output logic       trapped
);
    localparam int DW = $clog2(DEBOUNCE_CYC + 1);
    typedef enum logic [1:0] {HALTED, RUNNING, TRAPPED} state_t;
    state_t state, state_n;
    logic [2:0] rate_q;
    logic [CNT_W-1:0] count, count_n, period;
    logic sync1, sync2, deb, deb_d;
    logic [DW-1:0] deb_cnt;
    logic step_req, rate_chg, wrap, tick_n, deb_done;
    always_comb begin
        period = rate_q == 3'd1 ? CNT_W'(25000000) :
                 rate_q == 3'd2 ? CNT_W'(12500000) :
                 rate_q == 3'd3 ? CNT_W'(5000) :
                 rate_q == 3'd4 ? CNT_W'(2500) :
                 rate_q == 3'd5 ? CNT_W'(2) : CNT_W'(50000000);
    end
    assign step_req = deb & ~deb_d;
    assign rate_chg = rate_sel != rate_q;
    assign wrap     = count == period - CNT_W'(1);
    assign deb_done = sync2 != deb && deb_cnt == DW'(DEBOUNCE_CYC - 1);
    always_comb begin
        state_n = state;
        case (state)
            HALTED:  state_n = run_en ? RUNNING : HALTED;
            RUNNING: state_n = halt_req ? TRAPPED : (run_en ? RUNNING : HALTED);
            TRAPPED: state_n = run_en ? TRAPPED : HALTED;
            default: state_n = HALTED;
        endcase
    end
    // A tick due this cycle is issued even if the state is about to leave RUNNING.
    always_comb begin
        tick_n  = (state == RUNNING && wrap && !rate_chg) || (step_req && state != RUNNING);
        count_n = (rate_chg || state != RUNNING || state_n != RUNNING || wrap) ? '0 : count + CNT_W'(1);
    end
    always_ff @(posedge clkIn) begin
        if (!rstN) begin
            state   <= HALTED;
            count   <= '0;
            rate_q  <= rate_sel;
            tick    <= 1'b0;
            clkOut  <= 1'b0;
            running <= 1'b0;
            trapped <= 1'b0;
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            deb     <= 1'b0;
            deb_d   <= 1'b0;
            deb_cnt <= '0;
        end else begin
            state   <= state_n;
            count   <= count_n;
            rate_q  <= rate_sel;
            tick    <= tick_n;
            clkOut  <= clkOut ^ tick_n;
            running <= state_n == RUNNING;
            trapped <= state_n == TRAPPED;
            sync1   <= step_btn;
            sync2   <= sync1;
            deb     <= deb_done ? sync2 : deb;
            deb_d   <= deb;
            deb_cnt <= (sync2 == deb || deb_done) ? '0 : deb_cnt + DW'(1);
        end
    end
endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// tb_cpu_clk_ctrl: scoreboard of expected tick cycles plus state checks.
module tb_cpu_clk_ctrl;
    logic clkIn, rstN, run_en, step_btn, halt_req;
    logic [2:0] rate_sel;
    logic tick, clkOut, running, trapped;
    logic rst_seen, exp_clk, mon_en;
    int cyc, n_chk, n_pass, exp_t;
    int e, x, s, e2, h, s2, d, e3;
    int q[$];

    cpu_clk_ctrl #(.DEBOUNCE_CYC(4), .CNT_W(26)) dut (
        .clkIn(clkIn), .rstN(rstN), .rate_sel(rate_sel), .run_en(run_en),
        .step_btn(step_btn), .halt_req(halt_req), .tick(tick), .clkOut(clkOut),
        .running(running), .trapped(trapped)
    );

    initial clkIn = 1'b0;
    always #5 clkIn = ~clkIn;

    initial begin
        cyc = 0;
        rst_seen = 1'b1;
    end
    always @(posedge clkIn) begin
        cyc <= cyc + 1;
        rst_seen <= !rstN;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clkIn);
    endtask

    always @(negedge clkIn) begin
        if (mon_en) begin
            if (rst_seen) begin
                exp_clk = 1'b0;
                check("rst_tick", int'(tick), 0);
            end
            while (q.size() > 0 && q[0] < cyc) check("tick_miss", cyc, q.pop_front());
            if (tick) begin
                exp_t = 0;
                if (q.size() > 0) exp_t = q.pop_front();
                check("tick_cyc", cyc, exp_t);
                exp_clk = ~exp_clk;
            end
            check("clk_out", int'(clkOut), int'(exp_clk));
        end
    end

    initial begin
        n_chk = 0; n_pass = 0; mon_en = 1'b0; exp_clk = 1'b0;
        rstN = 1'b0; rate_sel = 3'd5; run_en = 1'b0; step_btn = 1'b0; halt_req = 1'b0;
        repeat (3) @(negedge clkIn);
        check("rst_tick0", int'(tick), 0);
        check("rst_clk0", int'(clkOut), 0);
        check("rst_run0", int'(running), 0);
        check("rst_trap0", int'(trapped), 0);
        rstN = 1'b1;
        mon_en = 1'b1;
        wait_until(103);
        check("idle_run", int'(running), 0);
        // rate 5 run, then switch to rate 4 on the edge a tick would have fallen
        e = cyc;
        for (int k = 0; k < 10; k++) q.push_back(e + 3 + 2 * k);
        q.push_back(e + 23 + 2500);
        q.push_back(e + 23 + 5000);
        q.push_back(e + 23 + 7500);
        run_en = 1'b1;
        wait_until(e + 1);
        check("run_on", int'(running), 1);
        wait_until(e + 22);
        rate_sel = 3'd4;
        wait_until(e + 7522);
        halt_req = 1'b1;
        wait_until(e + 7523);
        halt_req = 1'b0;
        check("trap_on", int'(trapped), 1);
        check("trap_run", int'(running), 0);
        wait_until(e + 12523);
        check("trap_hold", int'(trapped), 1);
        x = cyc;
        run_en = 1'b0;
        wait_until(x + 1);
        check("halt_run", int'(running), 0);
        check("halt_trap", int'(trapped), 0);
        // bounce shorter than the debounce window
        s = x + 5;
        wait_until(s);
        step_btn = 1'b1;
        wait_until(s + 2);
        step_btn = 1'b0;
        s = s + 30;
        wait_until(s);
        q.push_back(s + 7);
        step_btn = 1'b1;
        wait_until(s + 10);
        step_btn = 1'b0;
        wait_until(s + 40);
        rate_sel = 3'd5;
        e2 = s + 45;
        wait_until(e2);
        for (int k = 0; k < 4; k++) q.push_back(e2 + 3 + 2 * k);
        run_en = 1'b1;
        wait_until(e2 + 1);
        check("run_on2", int'(running), 1);
        h = e2 + 9;
        wait_until(h);
        halt_req = 1'b1;
        wait_until(h + 1);
        halt_req = 1'b0;
        check("trap_on2", int'(trapped), 1);
        check("trap_run2", int'(running), 0);
        wait_until(h + 21);
        check("trap_hold2", int'(trapped), 1);
        s2 = cyc;
        q.push_back(s2 + 7);
        step_btn = 1'b1;
        wait_until(s2 + 10);
        step_btn = 1'b0;
        wait_until(s2 + 40);
        check("trap_step", int'(trapped), 1);
        d = cyc;
        run_en = 1'b0;
        wait_until(d + 1);
        check("halt_run2", int'(running), 0);
        check("halt_trap2", int'(trapped), 0);
        e3 = d + 5;
        wait_until(e3);
        for (int k = 0; k < 4; k++) q.push_back(e3 + 3 + 2 * k);
        run_en = 1'b1;
        wait_until(e3 + 1);
        check("run_on3", int'(running), 1);
        wait_until(e3 + 9);
        check("clk_hi", int'(clkOut), 1);
        rstN = 1'b0;
        wait_until(e3 + 10);
        check("mid_rst_tick", int'(tick), 0);
        check("mid_rst_clk", int'(clkOut), 0);
        check("mid_rst_run", int'(running), 0);
        check("mid_rst_trap", int'(trapped), 0);
        rstN = 1'b1;
        q.push_back(e3 + 13);
        q.push_back(e3 + 15);
        wait_until(e3 + 14);
        run_en = 1'b0;
        wait_until(e3 + 15);
        check("drop_run", int'(running), 0);
        wait_until(e3 + 40);
        check("q_empty", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
